// File: rtl/redirect_cmd_decoder.sv
// Observe-only decoder of redirect commands on N_PORT write channels.
// Each port runs its own IDLE -> WAIT_TGT -> ACTIVE tracker with timeout and commit count.
module redirect_cmd_decoder #(
  parameter int unsigned       N_PORT       = 7,
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       LOG_N_INIT   = 2,
  parameter logic [DATA_W-1:0] CMD_REDIRECT = 64'hE44_0000_0000_0001,
  parameter logic [DATA_W-1:0] CMD_STOP     = 64'hE44_0000_0000_0002,
  parameter int unsigned       TGT_LSB      = 32,
  parameter int unsigned       TIMEOUT      = 16,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORT*DATA_W-1:0]     wdata_i,
  input  logic [N_PORT-1:0]            wvalid_i,
  input  logic [N_PORT-1:0]            wready_i,
  input  logic [N_PORT*LOG_N_INIT-1:0] wsrc_i,
  output logic [N_PORT-1:0]            redirect_valid_o,
  output logic [N_PORT*LOG_N_INIT-1:0] source_o,
  output logic [N_PORT*LOG_N_INIT-1:0] target_o,
  output logic [N_PORT-1:0]            err_o,
  output logic [N_PORT*CNT_W-1:0]      commit_cnt_o
);

  localparam int unsigned TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned HI_LSB = TGT_LSB + LOG_N_INIT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    state_e                state_q, state_d;
    logic [LOG_N_INIT-1:0] src_q, src_d;
    logic [LOG_N_INIT-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  err_q, err_d;
    logic                  act_q, act_d;

    logic [DATA_W-1:0]     data_c;
    logic [LOG_N_INIT-1:0] wsrc_c;
    logic [LOG_N_INIT-1:0] t_c;
    logic                  beat_c;
    logic                  is_redir_c;
    logic                  is_stop_c;
    logic                  hi_nz_c;

    assign data_c     = wdata_i[p*DATA_W +: DATA_W];
    assign wsrc_c     = wsrc_i[p*LOG_N_INIT +: LOG_N_INIT];
    assign beat_c     = wvalid_i[p] & wready_i[p];
    assign is_redir_c = (data_c == CMD_REDIRECT);
    assign is_stop_c  = (data_c == CMD_STOP);
    assign t_c        = data_c[TGT_LSB +: LOG_N_INIT];
    assign hi_nz_c    = ((data_c >> HI_LSB) != '0);

    // Next-state and next-output logic for this port.
    always_comb begin
      state_d = state_q;
      src_d   = src_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      err_d   = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (beat_c && is_redir_c) begin
            state_d = S_WAIT;
            src_d   = wsrc_c;
            to_d    = '0;
          end
        end
        S_WAIT: begin
          if (beat_c) begin
            if (is_stop_c) begin
              state_d = S_IDLE;
            end else if (hi_nz_c || (t_c == src_q)) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = S_ACTIVE;
              tgt_d   = t_c;
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (TIMEOUT > 0) begin
            // A beat in the expiring cycle takes priority over the timeout.
            if (to_q == TO_W'(TIMEOUT - 1)) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end else begin
              to_d = to_q + TO_W'(1);
            end
          end
        end
        S_ACTIVE: begin
          if (beat_c && is_stop_c) begin
            state_d = S_IDLE;
          end else if (beat_c && is_redir_c) begin
            state_d = S_WAIT;
            src_d   = wsrc_c;
            to_d    = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      act_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        src_q   <= '0;
        tgt_q   <= '0;
        cnt_q   <= '0;
        to_q    <= '0;
        err_q   <= 1'b0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        src_q   <= src_d;
        tgt_q   <= tgt_d;
        cnt_q   <= cnt_d;
        to_q    <= to_d;
        err_q   <= err_d;
        act_q   <= act_d;
      end
    end

    assign redirect_valid_o[p]                      = act_q;
    assign err_o[p]                                 = err_q;
    assign source_o[p*LOG_N_INIT +: LOG_N_INIT]     = src_q;
    assign target_o[p*LOG_N_INIT +: LOG_N_INIT]     = tgt_q;
    assign commit_cnt_o[p*CNT_W +: CNT_W]           = cnt_q;
  end

endmodule

// File: tb/tb_redirect_cmd_decoder.sv
// Bench for redirect_cmd_decoder: directed scenarios then randomized traffic,
// every cycle compared against a behavioural per-port model.
module tb_redirect_cmd_decoder;

  localparam int N     = 7;
  localparam int DW    = 64;
  localparam int IW    = 2;
  localparam int CW    = 8;
  localparam int TOUT  = 16;
  localparam logic [63:0] REDIR = 64'hE44_0000_0000_0001;
  localparam logic [63:0] STOP  = 64'hE44_0000_0000_0002;

  logic              clk;
  logic              rst_n;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      wvalid;
  logic [N-1:0]      wready;
  logic [N*IW-1:0]   wsrc;
  logic [N-1:0]      rv;
  logic [N*IW-1:0]   src_o;
  logic [N*IW-1:0]   tgt_o;
  logic [N-1:0]      err;
  logic [N*CW-1:0]   cnt_o;

  int nchecks = 0;
  int nerr    = 0;

  // Model: 0 = idle, 1 = waiting for target, 2 = active
  int m_mode   [N];
  int m_src    [N];
  int m_tgt    [N];
  int m_cnt    [N];
  int m_waited [N];
  int m_err    [N];

  redirect_cmd_decoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wdata_i          (wdata),
    .wvalid_i         (wvalid),
    .wready_i         (wready),
    .wsrc_i           (wsrc),
    .redirect_valid_o (rv),
    .source_o         (src_o),
    .target_o         (tgt_o),
    .err_o            (err),
    .commit_cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int p, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s port%0d observed=%0h expected=%0h", tag, p, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wdata  = '0;
    wvalid = '0;
    wready = '0;
    wsrc   = '0;
  endtask

  task automatic drive(input int p, input logic [63:0] d, input int s, input bit v, input bit r);
    wdata[p*DW +: DW] = d;
    wsrc[p*IW +: IW]  = IW'(s);
    wvalid[p]         = v;
    wready[p]         = r;
  endtask

  // Apply the rules to the inputs present at the clock edge.
  task automatic model_update();
    for (int p = 0; p < N; p++) begin
      logic [63:0] d;
      bit beat;
      int t;
      d    = wdata[p*DW +: DW];
      beat = wvalid[p] && wready[p];
      t    = int'((d >> 32) & 64'h3);
      m_err[p] = 0;
      if (!rst_n) begin
        m_mode[p] = 0; m_src[p] = 0; m_tgt[p] = 0; m_cnt[p] = 0; m_waited[p] = 0;
      end else if (m_mode[p] == 0) begin
        if (beat && d == REDIR) begin
          m_mode[p] = 1; m_src[p] = int'(wsrc[p*IW +: IW]); m_waited[p] = 0;
        end
      end else if (m_mode[p] == 1) begin
        if (beat) begin
          if (d == STOP) m_mode[p] = 0;
          else if ((d >> 34) != 0 || t == m_src[p]) begin
            m_mode[p] = 0; m_err[p] = 1;
          end else begin
            m_mode[p] = 2; m_tgt[p] = t;
            m_cnt[p] = (m_cnt[p] + 1 > 255) ? 255 : m_cnt[p] + 1;
          end
        end else begin
          m_waited[p]++;
          if (m_waited[p] == TOUT) begin
            m_mode[p] = 0; m_err[p] = 1;
          end
        end
      end else begin
        if (beat && d == STOP) m_mode[p] = 0;
        else if (beat && d == REDIR) begin
          m_mode[p] = 1; m_src[p] = int'(wsrc[p*IW +: IW]); m_waited[p] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < N; p++) begin
      chk("redirect_valid", p, 64'(rv[p]), 64'(m_mode[p] == 2));
      chk("err", p, 64'(err[p]), 64'(m_err[p]));
      chk("source", p, 64'(src_o[p*IW +: IW]), 64'(m_src[p]));
      chk("target", p, 64'(tgt_o[p*IW +: IW]), 64'(m_tgt[p]));
      chk("commit_cnt", p, 64'(cnt_o[p*CW +: CW]), 64'(m_cnt[p]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  function automatic logic [63:0] rand_data();
    logic [63:0] d;
    int k;
    d = {32'($urandom), 32'($urandom)};
    k = $urandom_range(0, 5);
    case (k)
      0, 1:    d = REDIR;
      2:       d = STOP;
      3, 4:    d[63:34] = '0;
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    for (int p = 0; p < N; p++) begin
      m_mode[p] = 0; m_src[p] = 0; m_tgt[p] = 0; m_cnt[p] = 0; m_waited[p] = 0; m_err[p] = 0;
    end
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    chk("reset_valid", 0, 64'(rv), 64'(0));
    chk("reset_cnt", 0, 64'(cnt_o[CW-1:0]), 64'(0));
    rst_n = 1'b1;

    // Port 0 commits target 2 from source 1
    drive(0, REDIR, 1, 1, 1); step(); clear_inputs();
    drive(0, 64'h2_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p0_target", 0, 64'(tgt_o[1:0]), 64'd2);
    chk("p0_source", 0, 64'(src_o[1:0]), 64'd1);
    chk("p0_valid", 0, 64'(rv[0]), 64'd1);
    chk("p0_cnt", 0, 64'(cnt_o[7:0]), 64'd1);
    step();

    // Port 3: target equals source -> error pulse
    drive(3, REDIR, 2, 1, 1); step(); clear_inputs();
    drive(3, 64'h2_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p3_err", 3, 64'(err[3]), 64'd1);
    chk("p3_valid", 3, 64'(rv[3]), 64'd0);
    step();
    chk("p3_err_single", 3, 64'(err[3]), 64'd0);

    // Port 1: upper target bits set -> error, target unchanged
    drive(1, REDIR, 0, 1, 1); step(); clear_inputs();
    drive(1, 64'h5_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p1_err", 1, 64'(err[1]), 64'd1);
    chk("p1_target", 1, 64'(tgt_o[3:2]), 64'd0);
    step();

    // Port 6: timeout after 16 idle cycles, stalled beats do not count
    drive(6, REDIR, 0, 1, 1); step(); clear_inputs();
    for (int c = 0; c < 16; c++) begin
      if (c % 3 == 0) drive(6, 64'h1_0000_0000, 0, 1, 0);
      step();
      clear_inputs();
      if (c < 15) chk("p6_no_early_err", 6, 64'(err[6]), 64'd0);
    end
    chk("p6_timeout_err", 6, 64'(err[6]), 64'd1);
    drive(6, 64'h1_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p6_late_valid", 6, 64'(rv[6]), 64'd0);
    chk("p6_late_target", 6, 64'(tgt_o[13:12]), 64'd0);

    // Port 2 stops while port 4 commits in the same cycle
    drive(2, REDIR, 0, 1, 1); drive(4, REDIR, 0, 1, 1); step(); clear_inputs();
    drive(2, 64'h3_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p2_active", 2, 64'(rv[2]), 64'd1);
    drive(2, STOP, 0, 1, 1); drive(4, 64'h1_0000_0000, 0, 1, 1); step(); clear_inputs();
    chk("p2_stopped", 2, 64'(rv[2]), 64'd0);
    chk("p2_target_held", 2, 64'(tgt_o[5:4]), 64'd3);
    chk("p4_valid", 4, 64'(rv[4]), 64'd1);
    chk("p4_target", 4, 64'(tgt_o[9:8]), 64'd1);

    // Port 5: saturate commit counter via repeated re-arm, then reset while active
    for (int i = 0; i < 260; i++) begin
      drive(5, REDIR, 0, 1, 1); step(); clear_inputs();
      drive(5, 64'h1_0000_0000, 0, 1, 1); step(); clear_inputs();
    end
    chk("p5_saturated", 5, 64'(cnt_o[47:40]), 64'd255);
    chk("p5_active", 5, 64'(rv[5]), 64'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_all_valid", 5, 64'(rv), 64'd0);
    chk("rst_all_err", 5, 64'(err), 64'd0);
    chk("rst_all_cnt", 5, 64'(cnt_o), 64'd0);
    chk("rst_all_tgt", 5, 64'(tgt_o), 64'd0);
    step();
    chk("rst_no_err_after", 5, 64'(err), 64'd0);

    // Randomized traffic on all ports
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        drive(p, rand_data(), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    clear_inputs();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
